// File: rtl/ws2812_frame_ctrl.sv
// ws2812_frame_ctrl: double-buffered pixel store that feeds one frame per refresh period to a WS2812 driver.
// Build option: define WS2812_BRIGHTNESS_EN to add a global brightness scaler (one extra cycle of latency).
module ws2812_frame_ctrl #(
  parameter int unsigned LEDS_NUM       = 7,
  parameter int unsigned REFRESH_CYCLES = 1_000_000,
  localparam int unsigned ADDR_W = (LEDS_NUM > 1) ? $clog2(LEDS_NUM) : 1,
  localparam int unsigned IDX_W  = $clog2(LEDS_NUM + 1),
  localparam int unsigned RW     = $clog2(REFRESH_CYCLES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              commit,
  input  logic [7:0]        brightness,
  input  logic              drv_req,
  input  logic [IDX_W-1:0]  drv_idx,
  output logic              drv_reset,
  output logic [31:0]       color_rgb,
  output logic              busy,
  output logic              swap_pending,
  output logic              frame_done,
  output logic              overrun
);

  localparam int unsigned AW1   = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** AW1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SERVE = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_d;
  logic [RW-1:0]    refresh_cnt;
  logic             tick_c;
  logic             drv_req_q;
  logic             req_rise;
  logic             front_sel;
  logic             last_seen;
  logic [IDX_W-1:0] idx_q;
  logic             swap_c;
  logic             load_c;
  logic [23:0]      rd_c;
  logic [23:0]      mem [DEPTH];

  assign tick_c = (refresh_cnt == RW'(REFRESH_CYCLES - 1));

  // Pixel store addressed {bank, index}; host always writes the back bank.
  always_ff @(posedge clock) begin
    if (wr_en && (AW1'(wr_addr) < AW1'(LEDS_NUM)))
      mem[{~front_sel, wr_addr}] <= wr_data;
  end

  // Indices past the last pixel read as black (driver's trailing slot).
  assign rd_c = (idx_q < IDX_W'(LEDS_NUM)) ? mem[{front_sel, ADDR_W'(idx_q)}] : 24'h000000;

  // Next-state logic.
  always_comb begin
    state_d = state;
    swap_c  = 1'b0;
    load_c  = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick_c && run) begin
          state_d = S_SERVE;
          swap_c  = swap_pending;
        end
      end
      S_SERVE: begin
        if (req_rise) state_d = S_FETCH;
      end
      S_FETCH: begin
        if ((idx_q == '0) && last_seen) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SERVE;
          load_c  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, sequencing registers and state-decoded outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      refresh_cnt  <= '0;
      drv_req_q    <= 1'b0;
      req_rise     <= 1'b0;
      front_sel    <= 1'b0;
      last_seen    <= 1'b0;
      idx_q        <= '0;
      swap_pending <= 1'b0;
      overrun      <= 1'b0;
      drv_reset    <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state       <= state_d;
      refresh_cnt <= tick_c ? '0 : refresh_cnt + RW'(1);
      drv_req_q   <= drv_req;
      req_rise    <= drv_req & ~drv_req_q;
      drv_reset   <= (state_d == S_IDLE) || (state_d == S_DONE);
      busy        <= (state_d == S_SERVE) || (state_d == S_FETCH);
      frame_done  <= (state_d == S_DONE);
      if (tick_c && (state != S_IDLE)) overrun <= 1'b1;
      if (swap_c) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end
      if (commit) swap_pending <= 1'b1;
      if ((state == S_SERVE) && req_rise) idx_q <= drv_idx;
      if ((state == S_IDLE) && (state_d == S_SERVE))
        last_seen <= 1'b0;
      else if (load_c && (idx_q >= IDX_W'(LEDS_NUM - 1)))
        last_seen <= 1'b1;
    end
  end

`ifdef WS2812_BRIGHTNESS_EN
  function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
    return 8'((16'(c) * (16'(b) + 16'd1)) >> 8);
  endfunction

  logic [23:0] raw_q;
  logic        raw_vld;

  // Fetched colour is staged one cycle, then scaled per channel.
  always_ff @(posedge clock) begin
    if (reset) begin
      raw_q     <= '0;
      raw_vld   <= 1'b0;
      color_rgb <= '0;
    end else begin
      raw_vld <= load_c;
      if (load_c) raw_q <= rd_c;
      if (raw_vld)
        color_rgb <= {8'h00, scale(raw_q[23:16], brightness),
                      scale(raw_q[15:8], brightness), scale(raw_q[7:0], brightness)};
    end
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;

  always_ff @(posedge clock) begin
    if (reset)       color_rgb <= '0;
    else if (load_c) color_rgb <= {8'h00, rd_c};
  end
`endif

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Randomised bench for ws2812_frame_ctrl (3 LEDs, 2000-cycle refresh) against a frame-level reference model.
`timescale 1ns/1ps
module tb_ws2812_frame_ctrl;
  localparam int N   = 3;
  localparam int REF = 2000;
  localparam int AW  = 2;
  localparam int IW  = 2;
`ifdef WS2812_BRIGHTNESS_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          run = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [23:0]   wr_data = '0;
  logic          commit = 1'b0;
  logic [7:0]    brightness = 8'hFF;
  logic          drv_req = 1'b0;
  logic [IW-1:0] drv_idx = '0;
  logic          drv_reset;
  logic [31:0]   color_rgb;
  logic          busy;
  logic          swap_pending;
  logic          frame_done;
  logic          overrun;

  ws2812_frame_ctrl #(.LEDS_NUM(N), .REFRESH_CYCLES(REF)) dut (
    .clock(clock), .reset(reset), .run(run), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit), .brightness(brightness), .drv_req(drv_req),
    .drv_idx(drv_idx), .drv_reset(drv_reset), .color_rgb(color_rgb), .busy(busy),
    .swap_pending(swap_pending), .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Cycles since reset release and count of frame_done pulses.
  int cyc = 0;
  int fd_count = 0;
  always @(posedge clock) begin
    cyc <= reset ? 0 : cyc + 1;
    if (frame_done === 1'b1) fd_count <= fd_count + 1;
  end

  // Reference model state.
  logic [23:0] bank [2][N];
  int          front;
  int          pend;
  logic        ovr_exp;
  logic [31:0] prev_color;
  int          earliest;
  int          start_cyc;
  int          done_cyc;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [23:0] expect_px(input int idx);
    logic [23:0] px;
    px = (idx < N) ? bank[front][idx] : 24'h000000;
`ifdef WS2812_BRIGHTNESS_EN
    for (int c = 0; c < 3; c++)
      px[c*8 +: 8] = 8'((int'(px[c*8 +: 8]) * (int'(brightness) + 1)) / 256);
`endif
    return px;
  endfunction

  task automatic apply_reset(input int cycles);
    reset = 1'b1; drv_req = 1'b0; wr_en = 1'b0; commit = 1'b0;
    @(negedge clock);
    check("rst_drv_reset", drv_reset, 1);
    check("rst_color", color_rgb, 0);
    check("rst_busy", busy, 0);
    check("rst_swap_pending", swap_pending, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overrun", overrun, 0);
    repeat (cycles - 1) @(negedge clock);
    reset = 1'b0;
    front = 0; pend = 0; ovr_exp = 1'b0; prev_color = '0; earliest = 1;
  endtask

  task automatic host_write(input int addr, input logic [23:0] data);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
    @(negedge clock);
    wr_en = 1'b0;
    if (addr < N) bank[1 - front][addr] = data;
  endtask

  task automatic host_commit();
    commit = 1'b1;
    @(negedge clock);
    commit = 1'b0;
    pend = 1;
    check("swap_pending_set", swap_pending, 1);
  endtask

  task automatic fill_back();
    for (int a = 0; a < N; a++) host_write(a, 24'($urandom));
  endtask

  task automatic wait_start();
    int n;
    int exp_start;
    n = 0;
    while (drv_reset === 1'b1 && n < 3 * REF) begin
      @(negedge clock);
      n++;
    end
    exp_start = ((earliest + REF - 1) / REF) * REF;
    check("frame_start_seen", drv_reset, 0);
    check("frame_start_cycle", cyc, exp_start);
    start_cyc = cyc;
    if (pend != 0) begin
      front = 1 - front;
      pend = 0;
    end
    check("swap_pending_clear", swap_pending, 0);
    check("busy_start", busy, 1);
  endtask

  task automatic drv_request(input int idx, input int hold, input bit wrap);
    logic [31:0] exp;
    exp = {8'h00, expect_px(idx)};
    drv_idx = IW'(idx);
    drv_req = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(negedge clock);
      if (k == LAT - 1) check("color_before_latency", color_rgb, prev_color);
      if (wrap && k == 3) begin
        check("done_pulse", frame_done, 1);
        check("drv_reset_end", drv_reset, 1);
        done_cyc = cyc;
      end
      if (k == LAT) begin
        if (wrap) check("color_kept_at_wrap", color_rgb, prev_color);
        else      check("color", color_rgb, exp);
      end
    end
    if (wrap) begin
      check("done_single_cycle", frame_done, 0);
      check("busy_after_frame", busy, 0);
    end else begin
      check("busy_mid", busy, 1);
      check("drv_reset_mid", drv_reset, 0);
      prev_color = exp;
    end
    drv_req = 1'b0;
  endtask

  // mode 0: no host traffic, 1: random writes/commits, 2: px1 update + commit after idx 0.
  task automatic run_frame(input int lo, input int hi, input int mode);
    int fd0;
    int idx;
    int gap;
    int r;
    wait_start();
    fd0 = fd_count;
    for (int i = 0; i <= N + 1; i++) begin
      idx = (i == N + 1) ? 0 : i;
      drv_request(idx, int'($urandom_range(hi, lo)), i == N + 1);
      gap = (mode == 2 && i == 0) ? 2 : int'($urandom_range(4, 1));
      for (int g = 0; g < gap; g++) begin
        r = int'($urandom_range(9, 0));
        if (mode == 2 && i == 0 && g == 0)      host_write(1, 24'h00FF00);
        else if (mode == 2 && i == 0 && g == 1) host_commit();
        else if (mode == 1 && i <= N && r < 4)  host_write(int'($urandom_range(2**AW - 1, 0)), 24'($urandom));
        else if (mode == 1 && i <= N && r == 4) host_commit();
        else @(negedge clock);
      end
    end
    check("frame_done_count", fd_count - fd0, 1);
    if (start_cyc + REF <= done_cyc + 1) ovr_exp = 1'b1;
    check("overrun", overrun, ovr_exp);
    earliest = done_cyc + 2;
  endtask

  initial begin
    int bad;
    int fd0;
    apply_reset(4);
    fill_back();
    host_commit();
    run_frame(LAT + 1, 10, 0);
    fill_back();
    run_frame(10, 10, 2);
    run_frame(LAT + 1, 10, 0);
`ifdef WS2812_BRIGHTNESS_EN
    host_write(0, 24'h80FF40);
    host_commit();
    brightness = 8'd127;
    run_frame(LAT + 1, 8, 0);
`endif
    for (int f = 0; f < 6; f++) begin
      case (f % 3)
        0:       brightness = 8'd0;
        1:       brightness = 8'd255;
        default: brightness = 8'($urandom);
      endcase
      run_frame(LAT + 1, 12, 1);
    end
    // Refresh gated off for three ticks.
    run = 1'b0;
    bad = 0;
    fd0 = fd_count;
    repeat (3 * REF) begin
      @(negedge clock);
      if (drv_reset !== 1'b1) bad++;
    end
    check("run0_drv_reset_low_cycles", bad, 0);
    check("run0_frame_done", fd_count - fd0, 0);
    run = 1'b1;
    if (cyc + 1 > earliest) earliest = cyc + 1;
    run_frame(LAT + 1, 10, 0);
    // Slow driver stretches a frame across a tick.
    run_frame(600, 600, 0);
    run_frame(LAT + 1, 10, 1);
    // Reset while serving idx 1.
    wait_start();
    drv_request(0, LAT + 2, 1'b0);
    @(negedge clock);
    drv_request(1, LAT + 2, 1'b0);
    apply_reset(2);
    fill_back();
    host_commit();
    run_frame(LAT + 1, 10, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected bench completion", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
